// File: rtl/wb_timer_pkg.sv
// -----------------------------------------------------------------------------
// wb_timer_pkg
// Shared definitions for the Wishbone timer: register selector encoding,
// CTRL/STATUS bit positions, writable-bit mask for CTRL, the COMPARE reset
// value and a byte-lane merge helper used by every register write.
// -----------------------------------------------------------------------------
package wb_timer_pkg;

    // Register selector taken from address[3:2]
    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    // Byte offsets inside the 16-byte window
    localparam logic [3:0] OFFS_CTRL    = 4'h0;
    localparam logic [3:0] OFFS_COUNT   = 4'h4;
    localparam logic [3:0] OFFS_COMPARE = 4'h8;
    localparam logic [3:0] OFFS_STATUS  = 4'hC;

    // CTRL fields
    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_RELOAD_BIT   = 1;
    localparam int CTRL_IRQ_EN_BIT   = 2;
    localparam int CTRL_PRESCALE_LSB = 8;
    localparam int PRESCALE_W        = 8;

    // Only these CTRL bits exist; everything else reads 0
    localparam logic [31:0] CTRL_WRITE_MASK = 32'h0000_FF07;

    // STATUS fields
    localparam int STATUS_MATCH_BIT = 0;

    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

    // Replace the bits of old_word selected by mask with new_word
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [31:0] mask);
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// -----------------------------------------------------------------------------
// wishbone_if
// Minimal classic Wishbone bundle (single transfer, no wait states needed).
//   slave  modport: cycle/strobe/write_enable/address/data_in/select in,
//                   ack/data_out out
//   master modport: mirror image of slave
// -----------------------------------------------------------------------------
interface wishbone_if;
    logic        cycle;
    logic        strobe;
    logic        write_enable;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [3:0]  select;
    logic        ack;
    logic [31:0] data_out;

    modport slave (
        input  cycle, strobe, write_enable, address, data_in, select,
        output ack, data_out
    );

    modport master (
        output cycle, strobe, write_enable, address, data_in, select,
        input  ack, data_out
    );
endinterface

// File: rtl/wb_timer_prescaler.sv
// -----------------------------------------------------------------------------
// wb_timer_prescaler
// 8-bit prescale counter producing one tick every (prescale_i + 1) cycles
// while enabled.
//   clk        system clock
//   rst        asynchronous active-high reset
//   enable_i   count when 1; counter forced to 0 when 0
//   clear_i    restart the count from 0 (prescale value being rewritten)
//   prescale_i terminal count
//   tick_o     high for the cycle in which the counter sits at prescale_i
// -----------------------------------------------------------------------------
module wb_timer_prescaler
    import wb_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    // Tick depends on registered state only
    assign tick_o = enable_i & (cnt_q == prescale_i);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || !enable_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// -----------------------------------------------------------------------------
// wb_timer
// Wishbone-mapped 32-bit timer with prescaler, compare match and interrupt.
//   BASE_ADDR  word-aligned base of the 16-byte register window
//   clk        system clock
//   rst        asynchronous active-high reset
//   bus        Wishbone responder (1-cycle ack, registered read data)
//   irq        STATUS.match AND CTRL.irq_en
// Registers: 0x0 CTRL, 0x4 COUNT, 0x8 COMPARE, 0xC STATUS (match, W1C).
// -----------------------------------------------------------------------------
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
)(
    input  logic       clk,
    input  logic       rst,
    wishbone_if.slave  bus,
    output logic       irq
);

    logic        ack_q,     ack_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [31:0] ctrl_q,    ctrl_d;
    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q,   match_d;

    logic        req;
    logic        hit;
    logic        wr;
    logic        rd;
    reg_sel_e    reg_sel;
    logic [31:0] lane_mask;
    logic [31:0] read_word;
    logic        prescale_clear;
    logic        tick;
    logic        match_set;

    // address[1:0] never participates in decode
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.address[1:0];

    // Expand byte selects to a bit mask
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{bus.select[gi]}};
        end
    endgenerate

    // Masking with ack_q forces the idle cycle between back-to-back acks
    assign req     = bus.cycle & bus.strobe & ~ack_q;
    assign hit     = (bus.address[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = reg_sel_e'(bus.address[3:2]);
    assign wr      = req &  bus.write_enable & hit;
    assign rd      = req & ~bus.write_enable & hit;

    // Any write touching the prescale byte restarts the prescaler
    assign prescale_clear = wr & (reg_sel == REG_CTRL) & bus.select[1];

    wb_timer_prescaler u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (ctrl_q[CTRL_ENABLE_BIT]),
        .clear_i    (prescale_clear),
        .prescale_i (ctrl_q[CTRL_PRESCALE_LSB +: PRESCALE_W]),
        .tick_o     (tick)
    );

    always_comb begin
        read_word = '0;
        case (reg_sel)
            REG_CTRL:    read_word = ctrl_q;
            REG_COUNT:   read_word = count_q;
            REG_COMPARE: read_word = compare_q;
            REG_STATUS:  read_word = {31'd0, match_q};
            default:     read_word = '0;
        endcase
    end

    always_comb begin
        ack_d     = req;
        // Zero unless a read hit is being acknowledged, so data_out is 0 with ack low
        rdata_d   = rd ? read_word : 32'd0;
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = match_q;
        match_set = 1'b0;

        if (wr && reg_sel == REG_CTRL) begin
            ctrl_d = merge_lanes(ctrl_q, bus.data_in, lane_mask & CTRL_WRITE_MASK);
        end

        if (wr && reg_sel == REG_COMPARE) begin
            compare_d = merge_lanes(compare_q, bus.data_in, lane_mask);
        end

        // A bus write to COUNT overrides the tick and suppresses the match check
        if (wr && reg_sel == REG_COUNT) begin
            count_d = merge_lanes(count_q, bus.data_in, lane_mask);
        end else if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                count_d   = ctrl_q[CTRL_RELOAD_BIT] ? 32'd0 : count_q + 32'd1;
            end else begin
                count_d   = count_q + 32'd1;
            end
        end

        if (wr && reg_sel == REG_STATUS && bus.select[0] && bus.data_in[STATUS_MATCH_BIT]) begin
            match_d = 1'b0;
        end
        // Setting takes priority over a simultaneous clear
        if (match_set) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= COMPARE_RESET;
            match_q   <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.data_out = rdata_q;
    assign irq          = match_q & ctrl_q[CTRL_IRQ_EN_BIT];

endmodule

// File: tb/tb_wb_timer.sv
// -----------------------------------------------------------------------------
// tb_wb_timer
// Directed stimulus for wb_timer with a cycle-level behavioural model of the
// register file and timer; outputs are compared against the model on every
// falling edge, and hand-computed literals are checked at key points.
// -----------------------------------------------------------------------------
module tb_wb_timer;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] MISS = 32'h2000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    logic checking = 1'b0;

    always #5 clk = ~clk;

    wishbone_if bus_if ();

    wb_timer #(.BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if),
        .irq (irq)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_en = 0, m_ar = 0, m_ie = 0;
    bit [7:0]  m_ps = 0;
    bit [31:0] m_count = 0;
    bit [31:0] m_cmp = 32'hFFFF_FFFF;
    bit        m_match = 0;
    int        m_run = 0;       // enabled cycles since the prescaler last restarted
    bit        m_ack = 0;
    bit [31:0] m_dout = 0;

    always @(posedge clk or posedge rst) begin : model
        bit        req, hit, wr, tick, set_m;
        bit [1:0]  idx;
        bit [31:0] mask, rdv, cw;
        if (rst) begin
            m_en = 0; m_ar = 0; m_ie = 0; m_ps = 0;
            m_count = 0; m_cmp = 32'hFFFF_FFFF; m_match = 0;
            m_run = 0; m_ack = 0; m_dout = 0;
        end else begin
            req  = bus_if.cycle && bus_if.strobe && !m_ack;
            hit  = (bus_if.address >> 4) == (BASE >> 4);
            idx  = bus_if.address[3:2];
            wr   = req && bus_if.write_enable && hit;
            mask = 0;
            for (int b = 0; b < 4; b++) if (bus_if.select[b]) mask[8*b +: 8] = 8'hFF;
            cw = {16'd0, m_ps, 5'd0, m_ie, m_ar, m_en};
            case (idx)
                2'd0: rdv = cw;
                2'd1: rdv = m_count;
                2'd2: rdv = m_cmp;
                default: rdv = {31'd0, m_match};
            endcase
            tick  = m_en && ((m_run % (int'(m_ps) + 1)) == int'(m_ps));
            set_m = 0;

            m_ack  = req;
            m_dout = (req && !bus_if.write_enable && hit) ? rdv : 32'd0;
            m_run  = m_en ? m_run + 1 : 0;

            if (wr && idx == 2'd1) m_count = (m_count & ~mask) | (bus_if.data_in & mask);
            else if (tick) begin
                if (m_count == m_cmp) begin
                    set_m = 1;
                    m_count = m_ar ? 32'd0 : m_count + 1;
                end else m_count = m_count + 1;
            end
            if (wr && idx == 2'd3 && bus_if.select[0] && bus_if.data_in[0]) m_match = 0;
            if (set_m) m_match = 1;
            if (wr && idx == 2'd2) m_cmp = (m_cmp & ~mask) | (bus_if.data_in & mask);
            if (wr && idx == 2'd0) begin
                cw = (cw & ~mask) | (bus_if.data_in & mask);
                m_en = cw[0]; m_ar = cw[1]; m_ie = cw[2]; m_ps = cw[15:8];
                if (bus_if.select[1]) m_run = 0;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (checking && !rst) begin
            check("ack",      {31'd0, bus_if.ack}, {31'd0, m_ack});
            check("data_out", bus_if.data_out,     m_dout);
            check("irq",      {31'd0, irq},        {31'd0, m_match && m_ie});
        end
    end

    // ---------------- bus tasks (start and end on a falling edge) ----------------
    task automatic bus_idle();
        bus_if.cycle = 0; bus_if.strobe = 0; bus_if.write_enable = 0;
        bus_if.address = 0; bus_if.data_in = 0; bus_if.select = 0;
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        bus_if.cycle = 1; bus_if.strobe = 1; bus_if.write_enable = 1;
        bus_if.address = addr; bus_if.data_in = data; bus_if.select = sel;
        @(posedge clk); @(negedge clk);
        check("write_ack", {31'd0, bus_if.ack}, 32'd1);
        $display("write addr=%h data=%h sel=%b ack=%b", addr, data, sel, bus_if.ack);
        bus_idle();
        @(negedge clk);
    endtask

    task automatic wb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus_if.cycle = 1; bus_if.strobe = 1; bus_if.write_enable = 0;
        bus_if.address = addr; bus_if.data_in = 0; bus_if.select = 4'hF;
        @(posedge clk); @(negedge clk);
        check({name, "_ack"}, {31'd0, bus_if.ack}, 32'd1);
        check(name, bus_if.data_out, exp);
        $display("read  addr=%h data=%h expect=%h ack=%b", addr, bus_if.data_out, exp, bus_if.ack);
        bus_idle();
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus_idle();
        rst = 1;
        repeat (3) @(negedge clk);
        check("rst_ack",  {31'd0, bus_if.ack}, 32'd0);
        check("rst_data", bus_if.data_out,     32'd0);
        check("rst_irq",  {31'd0, irq},        32'd0);
        rst = 0;
        checking = 1;
        @(negedge clk);

        // Reset values
        wb_read(BASE + 32'h8, 32'hFFFF_FFFF, "rst_compare");
        wb_read(BASE + 32'h0, 32'h0, "rst_ctrl");
        wb_read(BASE + 32'h4, 32'h0, "rst_count");
        wb_read(BASE + 32'hC, 32'h0, "rst_status");

        // Byte-lane write
        wb_write(BASE + 32'h4, 32'hAABB_CCDD, 4'b0101);
        wb_read(BASE + 32'h4, 32'h00BB_00DD, "lane_count");
        wb_write(BASE + 32'h4, 32'h0, 4'hF);

        // CTRL only keeps its defined bits
        wb_write(BASE + 32'h0, 32'hFFFF_FFF8, 4'hF);
        wb_read(BASE + 32'h0, 32'h0000_FF00, "ctrl_mask");
        wb_write(BASE + 32'h0, 32'h0, 4'hF);

        // Compare match with auto-reload, prescale 0
        wb_write(BASE + 32'h8, 32'd3, 4'hF);
        wb_write(BASE + 32'h0, 32'h0000_0007, 4'hF);
        repeat (2) @(negedge clk);
        check("irq_before_match", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_at_match", {31'd0, irq}, 32'd1);
        wb_write(BASE + 32'h0, 32'h0000_0006, 4'hF);
        wb_read(BASE + 32'h4, 32'd1, "count_after_reload");
        wb_read(BASE + 32'hC, 32'd1, "status_match");
        wb_write(BASE + 32'hC, 32'd1, 4'b0001);
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Prescale 4, wrap without flag
        wb_write(BASE + 32'h0, 32'h0, 4'hF);
        wb_write(BASE + 32'h8, 32'd5, 4'hF);
        wb_write(BASE + 32'h4, 32'hFFFF_FFFE, 4'hF);
        wb_write(BASE + 32'h0, 32'h0000_0401, 4'hF);
        repeat (4) @(negedge clk);
        wb_read(BASE + 32'h4, 32'hFFFF_FFFF, "count_5_cycles");
        repeat (3) @(negedge clk);
        wb_read(BASE + 32'h4, 32'h0, "count_10_cycles");
        wb_read(BASE + 32'hC, 32'h0, "no_match_wrap");

        // Address miss
        wb_write(BASE + 32'h0, 32'h0, 4'hF);
        wb_write(BASE + 32'h4, 32'h55, 4'hF);
        wb_read(MISS, 32'h0, "miss_read");
        for (int i = 0; i < 4; i++) wb_write(MISS + 32'(4 * i), 32'hFFFF_FFFF, 4'hF);
        wb_read(BASE + 32'h0, 32'h0, "miss_ctrl");
        wb_read(BASE + 32'h4, 32'h55, "miss_count");
        wb_read(BASE + 32'hB, 32'd5, "miss_compare_lowbits");
        wb_read(BASE + 32'hC, 32'h0, "miss_status");

        // Reset during a pending write
        bus_if.cycle = 1; bus_if.strobe = 1; bus_if.write_enable = 1;
        bus_if.address = BASE + 32'h4; bus_if.data_in = 32'd7; bus_if.select = 4'hF;
        #2 rst = 1;
        @(posedge clk); @(negedge clk);
        check("rst_mid_ack", {31'd0, bus_if.ack}, 32'd0);
        $display("reset asserted during write of COUNT=7, ack=%b", bus_if.ack);
        bus_idle();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        wb_read(BASE + 32'h4, 32'h0, "count_after_rst");
        wb_read(BASE + 32'h8, 32'hFFFF_FFFF, "compare_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000: word-aligned base of the 16-byte register window.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 bus  wishbone_if.slave  -  Wishbone responder port, members listed in REQ-005..REQ-012.
REQ-005 bus.cycle  input  1  bus cycle in progress.
REQ-006 bus.strobe  input  1  transfer request.
REQ-007 bus.write_enable  input  1  1 = write, 0 = read.
REQ-008 bus.address  input  32  byte address.
REQ-009 bus.data_in  input  32  write data from initiator.
REQ-010 bus.select  input  4  byte-lane enables; bit n covers data[8n+7:8n].
REQ-011 bus.ack  output  1  single-cycle transfer acknowledge.
REQ-012 bus.data_out  output  32  read data, valid while ack=1.
REQ-013 irq  output  1  level interrupt = STATUS.match AND CTRL.irq_en.

Function
REQ-014 Register map (offset from BASE_ADDR): 0x0 CTRL, 0x4 COUNT, 0x8 COMPARE, 0xC STATUS.
REQ-015 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en, bits[15:8] prescale; all other bits read 0, writes ignored.
REQ-016 STATUS: bit0 match; write 1 clears, write 0 no effect; other bits read 0.
REQ-017 Request = cycle AND strobe AND NOT ack; on request, ack SHALL be 1 in the following cycle for exactly one cycle (latency 1, no wait states).
REQ-018 Back-to-back requests SHALL see ack low for at least one cycle between acks.
REQ-019 Write takes effect on the same edge ack rises; only lanes with select bit = 1 are updated.
REQ-020 Read data registered on the edge ack rises; full 32-bit word returned regardless of select.
REQ-021 data_out SHALL be 0 whenever ack = 0.
REQ-022 Address decode: hit iff address[31:4] == BASE_ADDR[31:4]; register chosen by address[3:2]; address[1:0] ignored.
REQ-023 Miss: still ack in one cycle (no hang); read returns 0; write discarded.
REQ-024 Prescaler: 8-bit counter, runs only when enable=1; tick when prescaler == prescale, then prescaler wraps to 0; prescale=0 gives tick every cycle.
REQ-025 enable=0: prescaler held at 0, COUNT held, no ticks.
REQ-026 On tick: if COUNT == COMPARE, set match and COUNT <= 0 when auto_reload=1 else COUNT+1; otherwise COUNT+1.
REQ-027 COUNT wraps 32'hFFFF_FFFF -> 0 with no flag.
REQ-028 Bus write to COUNT in same cycle as tick: bus value wins; no match evaluated that cycle.
REQ-029 Write-1-to-clear of match in same cycle as match set: set wins.
REQ-030 Write to CTRL.prescale SHALL reset the prescaler counter to 0.
REQ-031 irq combinational from registered state only; no bus-to-irq combinational path.

Reset
REQ-032 On rst: ack=0, data_out=0, CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, prescaler=0, irq=0.
REQ-033 rst asserted mid-transfer: ack drops immediately; pending write discarded; initiator re-issues after reset.

Structure
REQ-034 Package wb_timer_pkg holds register offsets, CTRL/STATUS bit positions, and COMPARE reset constant.
REQ-035 One sub-module, wb_timer_prescaler (8-bit counter, enable, load-clear, tick out); bus decode and registers stay in wb_timer.

Verification
REQ-036 Reset then read 0x8 -> ack one cycle after strobe, data 32'hFFFF_FFFF; reads of 0x0/0x4/0xC return 0.
REQ-037 Write 0x4 = 32'hAABB_CCDD with select=4'b0101, then read -> 32'h00BB_00DD.
REQ-038 COMPARE=3, CTRL=32'h0000_0007 (prescale 0) -> match and irq high 4 cycles after enable; COUNT back to 0 next tick; write STATUS=1 -> irq low next cycle.
REQ-039 prescale=4, auto_reload=0, COUNT=32'hFFFF_FFFE -> COUNT=32'hFFFF_FFFF after 5 cycles, 0 after 10; no match with COMPARE=5.
REQ-040 Read 32'h2000_0000 -> ack after one cycle, data 0; write there -> all registers unchanged.
REQ-041 Assert rst while ack pending on write of COUNT=7 -> ack never rises, COUNT=0 after reset.
